video_timing_irq: RTL and testbench



---
 rtl/video_timing_irq.sv | 161 ++++++++++++++++
 tb/tb_video_timing_irq.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_irq.sv
// Raster timing generator with line-compare and vblank interrupt controller.
// Counters advance every pixel clock; all decodes are combinational from them.
module video_timing_irq #(
  parameter int H_ACTIVE    = 352,
  parameter int H_FP        = 10,
  parameter int H_SYNC      = 32,
  parameter int H_BP        = 56,
  parameter int V_ACTIVE    = 240,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 10,
  parameter int H_BORDER    = 16,
  parameter int V_BORDER    = 20,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int HPOS_W      = 9,
  parameter int VPOS_W      = 9,
  parameter int NUM_LINEIRQ = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        io_addr,
  input  logic [7:0]        io_wrdata,
  input  logic              io_wren,
  output logic [7:0]        io_rddata,
  output logic [HPOS_W-1:0] hpos,
  output logic [VPOS_W-1:0] vpos,
  output logic              hsync,
  output logic              vsync,
  output logic              hblank,
  output logic              vblank,
  output logic              blank,
  output logic              hborder,
  output logic              vborder,
  output logic              hlast,
  output logic              vnext,
  output logic              irq
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int NIRQ    = NUM_LINEIRQ + 1;

  localparam logic [HPOS_W-1:0] H_LAST   = HPOS_W'(H_TOTAL - 1);
  localparam logic [HPOS_W-1:0] H_ACT    = HPOS_W'(H_ACTIVE);
  localparam logic [HPOS_W-1:0] H_SYNC_S = HPOS_W'(H_ACTIVE + H_FP);
  localparam logic [HPOS_W-1:0] H_SYNC_E = HPOS_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HPOS_W-1:0] H_BRD_L  = HPOS_W'(H_BORDER);
  localparam logic [HPOS_W-1:0] H_BRD_R  = HPOS_W'(H_ACTIVE - H_BORDER);

  localparam logic [VPOS_W-1:0] V_LAST   = VPOS_W'(V_TOTAL - 1);
  localparam logic [VPOS_W-1:0] V_ACT    = VPOS_W'(V_ACTIVE);
  localparam logic [VPOS_W-1:0] V_SYNC_S = VPOS_W'(V_ACTIVE + V_FP);
  localparam logic [VPOS_W-1:0] V_SYNC_E = VPOS_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VPOS_W-1:0] V_BRD_T  = VPOS_W'(V_BORDER);
  localparam logic [VPOS_W-1:0] V_BRD_B  = VPOS_W'(V_ACTIVE - V_BORDER);

  localparam logic [3:0] A_VPOS_LO = 4'h8;
  localparam logic [3:0] A_VPOS_HI = 4'h9;
  localparam logic [3:0] A_IRQMASK = 4'hA;
  localparam logic [3:0] A_IRQSTAT = 4'hB;
  localparam logic [3:0] A_FRAMECNT = 4'hC;

  logic [VPOS_W-1:0]      linecmp [NUM_LINEIRQ];
  logic [15:0]            cmp_ext [NUM_LINEIRQ];
  logic [NUM_LINEIRQ-1:0] match;
  logic [NUM_LINEIRQ-1:0] match_r;
  logic [NIRQ-1:0]        irqmask;
  logic [NIRQ-1:0]        irqstat;
  logic [NIRQ-1:0]        stat_set;
  logic [NIRQ-1:0]        stat_clr;
  logic [7:0]             framecnt;
  logic                   vblank_r;
  logic                   vblank_rise;
  logic [15:0]            wr_hi;
  logic [15:0]            vpos_ext;

  // Raster counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos <= '0;
      vpos <= '0;
    end else if (hlast) begin
      hpos <= '0;
      vpos <= (vpos == V_LAST) ? '0 : vpos + VPOS_W'(1);
    end else begin
      hpos <= hpos + HPOS_W'(1);
    end
  end

  assign hlast   = (hpos == H_LAST);
  assign vnext   = hlast;
  assign hblank  = (hpos >= H_ACT);
  assign vblank  = (vpos >= V_ACT);
  assign blank   = hblank | vblank;
  assign hborder = (hpos < H_BRD_L) || ((hpos >= H_BRD_R) && (hpos < H_ACT));
  assign vborder = (vpos < V_BRD_T) || ((vpos >= V_BRD_B) && (vpos < V_ACT));
  assign hsync   = ((hpos >= H_SYNC_S) && (hpos < H_SYNC_E)) ? HSYNC_POL : ~HSYNC_POL;
  assign vsync   = ((vpos >= V_SYNC_S) && (vpos < V_SYNC_E)) ? VSYNC_POL : ~VSYNC_POL;

  // IO bus: io_wren is a single-cycle strobe that commits on the next edge;
  // io_rddata is a pure decode of io_addr and the registers, no handshake or stall.
  assign wr_hi    = {io_wrdata, 8'h00};
  assign vpos_ext = 16'(vpos);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_LINEIRQ; k++) linecmp[k] <= '0;
    end else if (io_wren) begin
      for (int k = 0; k < NUM_LINEIRQ; k++) begin
        if (io_addr == 4'(2 * k))     linecmp[k][7:0]        <= io_wrdata;
        if (io_addr == 4'(2 * k + 1)) linecmp[k][VPOS_W-1:8] <= wr_hi[VPOS_W-1:8];
      end
    end
  end

  for (genvar k = 0; k < NUM_LINEIRQ; k++) begin : g_ch
    assign match[k]   = (vpos == linecmp[k]);
    assign cmp_ext[k] = 16'(linecmp[k]);
  end

  assign vblank_rise = vblank & ~vblank_r;
  assign stat_set    = {match & ~match_r, vblank_rise};
  assign stat_clr    = (io_wren && (io_addr == A_IRQSTAT)) ? io_wrdata[NIRQ-1:0] : '0;

  // match_r powers up as all-ones so a compare sitting on line 0 waits a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_r  <= '1;
      vblank_r <= 1'b0;
      irqmask  <= '0;
      irqstat  <= '0;
      framecnt <= 8'h00;
    end else begin
      match_r  <= match;
      vblank_r <= vblank;
      irqstat  <= (irqstat & ~stat_clr) | stat_set;
      if (io_wren && (io_addr == A_IRQMASK)) irqmask <= io_wrdata[NIRQ-1:0];
      if (vblank_rise) framecnt <= framecnt + 8'd1;
    end
  end

  assign irq = |(irqstat & irqmask);

  always_comb begin
    io_rddata = 8'h00;
    for (int k = 0; k < NUM_LINEIRQ; k++) begin
      if (io_addr == 4'(2 * k))     io_rddata = cmp_ext[k][7:0];
      if (io_addr == 4'(2 * k + 1)) io_rddata = cmp_ext[k][15:8];
    end
    case (io_addr)
      A_VPOS_LO:  io_rddata = vpos_ext[7:0];
      A_VPOS_HI:  io_rddata = vpos_ext[15:8];
      A_IRQMASK:  io_rddata = 8'(irqmask);
      A_IRQSTAT:  io_rddata = 8'(irqstat);
      A_FRAMECNT: io_rddata = framecnt;
      default:    ;
    endcase
  end

endmodule

// File: tb/tb_video_timing_irq.sv
// Bench for video_timing_irq on a small raster: a position/register model pushes the
// expected outputs after every edge, a negedge monitor pops and compares them.
module tb_video_timing_irq;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 6, VF = 1, VS = 1, VB = 1;
  localparam int HBD = 1, VBD = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int NL = 2;
  localparam int NIRQ = NL + 1;
  localparam int VPW = 9;
  localparam bit HPOL = 1'b0, VPOL = 1'b0;
  localparam int W = 28;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] io_addr = 4'h0;
  logic [7:0] io_wrdata = 8'h00;
  logic       io_wren = 1'b0;
  logic [7:0] io_rddata;
  logic [8:0] hpos, vpos;
  logic hsync, vsync, hblank, vblank, blank, hborder, vborder, hlast, vnext, irq;

  video_timing_irq #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_BORDER(HBD), .V_BORDER(VBD), .HSYNC_POL(HPOL), .VSYNC_POL(VPOL),
    .HPOS_W(9), .VPOS_W(VPW), .NUM_LINEIRQ(NL)
  ) dut (
    .clk(clk), .reset(reset), .io_addr(io_addr), .io_wrdata(io_wrdata), .io_wren(io_wren),
    .io_rddata(io_rddata), .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .vblank(vblank), .blank(blank), .hborder(hborder), .vborder(vborder),
    .hlast(hlast), .vnext(vnext), .irq(irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [W-1:0]  exp_q[$];
  logic [11:0]   rd_q[$];
  logic          rd_pending = 1'b0;
  int            n_checks = 0;
  int            n_errors = 0;

  // reference model: position is cycle count since reset, registers as plain ints
  int m_cyc = 0;
  int m_cmp [NL];
  int m_mask = 0, m_stat = 0, m_fcnt = 0;
  bit m_prev [NL];

  function automatic int cur_h();
    return m_cyc % HT;
  endfunction

  function automatic int cur_v();
    return (m_cyc / HT) % VT;
  endfunction

  function automatic logic [W-1:0] snapshot();
    int h, v;
    logic hs, vs, hb, vb, hbd, vbd, hl, ir;
    h   = cur_h();
    v   = cur_v();
    hs  = (h >= HA + HF && h < HA + HF + HS) ? HPOL : !HPOL;
    vs  = (v >= VA + VF && v < VA + VF + VS) ? VPOL : !VPOL;
    hb  = (h >= HA);
    vb  = (v >= VA);
    hbd = (h < HBD) || (h >= HA - HBD && h < HA);
    vbd = (v < VBD) || (v >= VA - VBD && v < VA);
    hl  = (h == HT - 1);
    ir  = ((m_stat & m_mask) != 0);
    return {9'(h), 9'(v), hs, vs, hb, vb, hb | vb, hbd, vbd, hl, hl, ir};
  endfunction

  function automatic logic [7:0] model_read(input logic [3:0] a);
    int ai, c;
    ai = int'(a);
    if (ai < 2 * NL) begin
      c = m_cmp[ai / 2];
      return (ai % 2 == 1) ? 8'(c >> 8) : 8'(c & 255);
    end
    case (ai)
      8:  return 8'(cur_v() & 255);
      9:  return 8'(cur_v() >> 8);
      10: return 8'(m_mask);
      11: return 8'(m_stat);
      12: return 8'(m_fcnt);
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    int mh, mv, mset, mclr, ai;
    bit now_m;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_cyc = 0; m_mask = 0; m_stat = 0; m_fcnt = 0;
        for (int k = 0; k < NL; k++) begin
          m_cmp[k] = 0;
          m_prev[k] = 1'b1;
        end
        exp_q.delete();
      end else begin
        mh = cur_h();
        mv = cur_v();
        mset = 0;
        if (mh == 0 && mv == VA) mset = 1;
        for (int k = 0; k < NL; k++) begin
          now_m = (mv == m_cmp[k]);
          if (now_m && !m_prev[k]) mset = mset | (1 << (k + 1));
          m_prev[k] = now_m;
        end
        ai = int'(io_addr);
        mclr = (io_wren && ai == 11) ? (int'(io_wrdata) & ((1 << NIRQ) - 1)) : 0;
        if (io_wren) begin
          if (ai < 2 * NL) begin
            if (ai % 2 == 1)
              m_cmp[ai / 2] = (m_cmp[ai / 2] & 255) | ((int'(io_wrdata) << 8) & ((1 << VPW) - 1));
            else
              m_cmp[ai / 2] = (m_cmp[ai / 2] & ~255) | int'(io_wrdata);
          end
          if (ai == 10) m_mask = int'(io_wrdata) & ((1 << NIRQ) - 1);
        end
        m_stat = (m_stat & ~mclr) | mset;
        if ((mset & 1) != 0) m_fcnt = (m_fcnt + 1) % 256;
        m_cyc++;
        exp_q.push_back(snapshot());
      end
    end
  end

  // scoreboard monitor
  initial begin
    logic [W-1:0] e, a;
    logic [11:0]  r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          a = {hpos, vpos, hsync, vsync, hblank, vblank, blank, hborder, vborder, hlast, vnext, irq};
          n_checks++;
          if (a[W-1:1] !== e[W-1:1]) begin
            n_errors++;
            $display("FAIL timing t=%0t act=%h exp=%h (hpos,vpos,hs,vs,hb,vb,b,hbd,vbd,hl,vn)", $time, a[W-1:1], e[W-1:1]);
          end
          n_checks++;
          if (a[0] !== e[0]) begin
            n_errors++;
            $display("FAIL irq t=%0t act=%b exp=%b", $time, a[0], e[0]);
          end
        end
        if (rd_pending && rd_q.size() > 0) begin
          r = rd_q.pop_front();
          n_checks++;
          if (io_rddata !== r[7:0]) begin
            n_errors++;
            $display("FAIL rddata t=%0t addr=%h act=%h exp=%h", $time, r[11:8], io_rddata, r[7:0]);
          end
        end
      end
    end
  end

  // driver tasks: all start and end at posedge+1
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic io_write(input logic [3:0] a, input logic [7:0] d);
    io_addr = a; io_wrdata = d; io_wren = 1'b1;
    step();
    io_wren = 1'b0;
  endtask

  task automatic io_read(input logic [3:0] a);
    io_addr = a;
    rd_q.push_back({a, model_read(a)});
    rd_pending = 1'b1;
    step();
    rd_pending = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    exp_q.delete();
    run(n);
    reset = 1'b0;
    exp_q.push_back(snapshot());
  endtask

  task automatic wait_pos(input int h, input int v, input int budget);
    int n;
    n = 0;
    while (!(cur_h() == h && cur_v() == v) && n < budget) begin
      step();
      n++;
    end
    if (!(cur_h() == h && cur_v() == v)) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_pos act=(%0d,%0d) exp=(%0d,%0d)", cur_h(), cur_v(), h, v);
    end
  endtask

  initial begin
    int r, n;
    #1;
    do_reset(3);

    // line 0 compare held through reset must not fire on the first line 0
    io_write(4'hA, 8'h04);
    run(20);
    io_read(4'hB);
    io_read(4'h8);
    io_read(4'h9);
    run(2 * HT * VT);
    io_read(4'hB);

    // line compare on line 3 drives irq, W1C drops it
    io_write(4'hB, 8'h07);
    io_write(4'h0, 8'h03);
    io_write(4'hA, 8'h02);
    wait_pos(4, 3, 2 * HT * VT);
    io_read(4'hB);
    io_write(4'hB, 8'h02);
    io_read(4'hB);
    run(HT * VT);

    // compare written to the current line mid-line fires on the next edge
    wait_pos(0, 4, 2 * HT * VT);
    io_write(4'hB, 8'h02);
    wait_pos(5, 5, 2 * HT * VT);
    io_write(4'h0, 8'h05);
    io_read(4'hB);
    io_read(4'h0);

    // out-of-range compares: 259 (high bit kept) and 300 never match
    io_write(4'hB, 8'h07);
    io_write(4'h1, 8'h01);
    io_write(4'h0, 8'h03);
    run(2 * HT * VT);
    io_read(4'hB);
    io_read(4'h1);
    io_write(4'h0, 8'h2C);
    io_write(4'hB, 8'h07);
    run(2 * HT * VT);
    io_read(4'hB);
    io_read(4'h0);
    io_read(4'h1);

    // random register traffic across the whole map
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) io_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      else if (r < 6) io_read(4'($urandom_range(0, 15)));
      else step();
    end

    // asynchronous reset mid-frame
    run($urandom_range(1, HT * VT - 1));
    do_reset(3);
    io_read(4'hB);
    io_read(4'hC);
    run(HT * VT + 5);

    // framecnt wrap with a W1C racing the vblank set
    io_write(4'hA, 8'h00);
    n = 0;
    while (m_fcnt != 255 && n < 260 * HT * VT) begin
      step();
      n++;
    end
    if (m_fcnt != 255) begin
      n_checks++;
      n_errors++;
      $display("FAIL fcnt_wait act=%0d exp=255", m_fcnt);
    end
    io_write(4'hB, 8'h01);
    io_read(4'hC);
    io_read(4'hB);
    wait_pos(0, VA, 2 * HT * VT);
    io_write(4'hB, 8'h01);
    io_read(4'hB);
    io_read(4'hC);

    // pending bit behind a zero mask, then unmask
    run(3);
    io_write(4'hA, 8'h01);
    io_read(4'hB);
    io_read(4'hA);
    run(HT * VT);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
